// File: rtl/core_io_responder.sv
// core_io_responder: serialises core `out` words onto a TX byte stream and
// assembles core `in` words from a buffered RX byte stream (little-endian).
// Ports: clk, rst (sync, active-low); core side out_req/out_data,
//   in_req/in_data, done, busy; UART side tx_data/tx_valid/tx_ready,
//   rx_data/rx_valid; sticky flags rx_overflow, proto_err.
// Optional: define CORE_IO_STATS_EN to add tx_words/rx_words done counters.
module core_io_responder #(
    parameter int WORD_BYTES    = 4,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_req,
    input  logic [31:0] out_data,
    input  logic        in_req,
    output logic [31:0] in_data,
    output logic        done,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_overflow,
    output logic        proto_err
`ifdef CORE_IO_STATS_EN
    ,
    output logic [15:0] tx_words,
    output logic [15:0] rx_words
`endif
);

    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);
    localparam logic [CW-1:0] FULL = CW'(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        TX,
        RX,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [31:0]   word;
    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          hs;
    logic          tx_last;
    logic          rx_last;

    // Occupancy is taken at the start of the cycle, so a byte arriving
    // this cycle is never popped in the same cycle it is written.
    assign full     = (count == FULL);
    assign push     = rx_valid && !full;
    assign pop      = (state == RX) && (count != '0);
    assign hs       = (state == TX) && tx_valid && tx_ready;
    assign idx_next = idx + 2'd1;
    assign tx_last  = hs && (idx == LAST);
    assign rx_last  = pop && (idx == LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
            if (rx_valid && full) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            in_data   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (out_req) begin
                        word     <= out_data;
                        idx      <= '0;
                        tx_data  <= out_data[7:0];
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= TX;
                        if (in_req) begin
                            proto_err <= 1'b1;
                        end
                    end else if (in_req) begin
                        in_data <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RX;
                    end
                end
                TX: begin
                    if (tx_last) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (hs) begin
                        idx     <= idx_next;
                        tx_data <= word[{idx_next, 3'b000} +: 8];
                    end
                end
                RX: begin
                    if (pop) begin
                        in_data[{idx, 3'b000} +: 8] <= mem[rd_ptr];
                        idx <= idx_next;
                    end
                    if (rx_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if ((state != IDLE) && (out_req || in_req)) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef CORE_IO_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_words <= '0;
            rx_words <= '0;
        end else begin
            if (tx_last) begin
                tx_words <= tx_words + 16'd1;
            end
            if (rx_last) begin
                rx_words <= rx_words + 16'd1;
            end
        end
    end
`endif

endmodule
